// File: rtl/sync_down_timer_if.sv
// ---------------------------------------------------------------------------
// sync_down_timer_if
//   Control/status bundle for sync_down_timer.
//
//   Handshake: there is no valid/ready pair. start and stop are single-cycle
//   command strobes sampled on the rising clock edge. en is a level-qualified
//   count tick. q/busy/done are registered status outputs with no
//   combinational path from any input.
//
//   Signals
//     start     : load load_val/periodic and begin counting (1-cycle pulse)
//     stop      : abort count, return to idle
//     en        : count-enable tick
//     periodic  : 1 = auto-reload, 0 = one-shot (sampled with start)
//     load_val  : start/period value (sampled with start)
//     q         : current count
//     busy      : high while counting
//     done      : one-cycle expiry pulse
//     dbg_state : FSM state (0 = IDLE, 1 = COUNT) for observation
// ---------------------------------------------------------------------------
interface sync_down_timer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             en;
    logic             periodic;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             dbg_state;

    modport master (
        output start, stop, en, periodic, load_val,
        input  q, busy, done, dbg_state
    );

    modport slave (
        input  start, stop, en, periodic, load_val,
        output q, busy, done, dbg_state
    );
endinterface

// File: rtl/sync_down_timer.sv
// ---------------------------------------------------------------------------
// sync_down_timer
//   Synchronous programmable down-counter timer with one-shot and periodic
//   modes. Loads a start value, decrements on each en tick, and flags expiry
//   with a one-cycle done pulse. All state lives on the single clk domain.
//
//   Ports
//     clk : system clock, all updates on the rising edge
//     rst : synchronous active-high reset
//     bus : sync_down_timer_if.slave (commands in, q/busy/done out)
//
//   Per-edge priority: rst > stop > start > count.
// ---------------------------------------------------------------------------
module sync_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    sync_down_timer_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;

    // Expiry condition when counting: the tick that takes q from 1 to "0".
    logic expire_now;
    assign expire_now = (state_q == COUNT) && bus.en && (q_q <= WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            q_q      <= '0;
            done_q   <= 1'b0;
            period_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            done_q   <= done_d;
            period_q <= period_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        done_d   = 1'b0;
        period_d = period_q;
        mode_d   = mode_q;

        if (bus.stop) begin
            // stop in IDLE has no effect; in COUNT it aborts without done.
            if (state_q == COUNT) begin
                state_d = IDLE;
                q_d     = '0;
            end
        end else if (bus.start) begin
            period_d = bus.load_val;
            mode_d   = bus.periodic;
            if (bus.load_val == '0) begin
                // Zero load expires immediately and never enters COUNT.
                state_d = IDLE;
                q_d     = '0;
                done_d  = 1'b1;
            end else begin
                state_d = COUNT;
                q_d     = bus.load_val;
                // A restart landing on an expiry edge still reports that expiry.
                done_d  = expire_now;
            end
        end else if (state_q == COUNT && bus.en) begin
            if (q_q > WIDTH'(1)) begin
                q_d = q_q - WIDTH'(1);
            end else begin
                done_d = 1'b1;
                if (mode_q) begin
                    q_d = period_q;
                end else begin
                    q_d     = '0;
                    state_d = IDLE;
                end
            end
        end
    end

    assign bus.q         = q_q;
    assign bus.busy      = (state_q == COUNT);
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sync_down_timer.sv
// ---------------------------------------------------------------------------
// tb_sync_down_timer
//   Directed bench: a table of {inputs, expected outputs} rows applied one
//   clock edge at a time, followed by hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_sync_down_timer;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;

    sync_down_timer_if #(.WIDTH(W)) bus ();

    sync_down_timer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic         rst;
        logic         start;
        logic         stop;
        logic         en;
        logic         per;
        logic [W-1:0] lv;
        logic [W-1:0] eq;
        logic         eb;
        logic         ed;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic p,
                                input logic e, input logic m, input logic [W-1:0] lv,
                                input logic [W-1:0] eq, input logic eb, input logic ed);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.en = e; v.per = m; v.lv = lv;
        v.eq = eq; v.eb = eb; v.ed = ed;
        vecs.push_back(v);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic s, input logic p,
                         input logic e, input logic m, input logic [W-1:0] lv);
        rst          = r;
        bus.start    = s;
        bus.stop     = p;
        bus.en       = e;
        bus.periodic = m;
        bus.load_val = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int idx,
                         input logic [W-1:0] eq, input logic eb, input logic ed);
        n_cmp++;
        if (bus.q !== eq || bus.busy !== eb || bus.done !== ed) begin
            n_bad++;
            $display("FAIL %s[%0d]: got q=%0d busy=%0b done=%0b, required q=%0d busy=%0b done=%0b",
                     tag, idx, bus.q, bus.busy, bus.done, eq, eb, ed);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.en = 1'b0;
        bus.periodic = 1'b0; bus.load_val = '0;

        //   rst st sp en per lv    q  busy done
        add(1, 0, 0, 0, 0,  0,    0, 0, 0);   // reset
        add(0, 0, 0, 0, 0,  0,    0, 0, 0);   // idle hold
        // one-shot, load 5
        add(0, 1, 0, 1, 0,  5,    5, 1, 0);
        add(0, 0, 0, 1, 0,  0,    4, 1, 0);
        add(0, 0, 0, 1, 0,  0,    3, 1, 0);
        add(0, 0, 0, 1, 0,  0,    2, 1, 0);
        add(0, 0, 0, 1, 0,  0,    1, 1, 0);
        add(0, 0, 0, 1, 0,  0,    0, 0, 1);   // expiry
        add(0, 0, 0, 1, 0,  0,    0, 0, 0);   // done lasts one cycle
        // zero load: immediate expiry, stays idle
        add(0, 1, 0, 1, 0,  0,    0, 0, 1);
        add(0, 0, 0, 1, 0,  0,    0, 0, 0);
        // stop in idle
        add(0, 0, 1, 1, 0,  0,    0, 0, 0);
        // start+stop together in COUNT
        add(0, 1, 0, 1, 0,  4,    4, 1, 0);
        add(0, 1, 1, 1, 0,  6,    0, 0, 0);
        // restart on expiry edge, then en gating holds q
        add(0, 1, 0, 1, 0,  2,    2, 1, 0);
        add(0, 0, 0, 1, 0,  0,    1, 1, 0);
        add(0, 1, 0, 1, 0,  7,    7, 1, 1);
        add(0, 0, 0, 0, 0,  0,    7, 1, 0);
        add(0, 0, 0, 0, 0,  0,    7, 1, 0);
        add(0, 0, 1, 0, 0,  0,    0, 0, 0);
        // stop on expiry edge
        add(0, 1, 0, 1, 1,  1,    1, 1, 0);
        add(0, 0, 1, 1, 1,  0,    0, 0, 0);
        // restart with zero load from COUNT
        add(0, 1, 0, 1, 0,  3,    3, 1, 0);
        add(0, 1, 0, 1, 0,  0,    0, 0, 1);
        // periodic with period 1: back-to-back done
        add(0, 1, 0, 1, 1,  1,    1, 1, 0);
        add(0, 0, 0, 1, 0,  0,    1, 1, 1);
        add(0, 0, 0, 1, 0,  0,    1, 1, 1);
        add(0, 0, 1, 1, 0,  0,    0, 0, 0);

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].en, vecs[i].per, vecs[i].lv);
            check("table", i, vecs[i].eq, vecs[i].eb, vecs[i].ed);
        end

        // ---- reset mid-count ----
        drive(0, 1, 0, 1, 0, 9);
        check("rst_mid", 0, 9, 1, 0);
        drive(0, 0, 0, 1, 0, 0);
        check("rst_mid", 1, 8, 1, 0);
        drive(0, 0, 0, 1, 0, 0);
        check("rst_mid", 2, 7, 1, 0);
        drive(1, 0, 0, 1, 0, 0);
        check("rst_mid", 3, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 0, 0);
            check("rst_mid_idle", k, 0, 0, 0);
        end

        // ---- periodic, gated en every other cycle: done every 6 cycles ----
        drive(0, 1, 0, 1, 1, 3);
        check("per_gated", 0, 3, 1, 0);
        for (int k = 1; k <= 24; k++) begin
            int e;
            logic [W-1:0] eq;
            e = k / 2;
            eq = W'(3 - (e % 3));
            drive(0, 0, 0, (k % 2 == 0), 0, 0);
            check("per_gated", k, eq, 1, (k % 6 == 0));
        end
        drive(0, 0, 1, 0, 0, 0);
        check("per_gated_stop", 0, 0, 0, 0);

        // ---- max load: done exactly 15 edges after start ----
        drive(0, 1, 0, 1, 0, 15);
        check("max_load", 0, 15, 1, 0);
        for (int k = 1; k <= 15; k++) begin
            drive(0, 0, 0, 1, 0, 0);
            if (k < 15) check("max_load", k, W'(15 - k), 1, 0);
            else        check("max_load", k, 0, 0, 1);
        end

        // ---- relatch: inputs changing without start do not affect reload ----
        drive(0, 1, 0, 1, 1, 3);
        check("relatch", 0, 3, 1, 0);
        drive(0, 0, 0, 1, 0, 9);
        check("relatch", 1, 2, 1, 0);
        drive(0, 0, 0, 1, 0, 9);
        check("relatch", 2, 1, 1, 0);
        drive(0, 0, 0, 1, 0, 9);
        check("relatch", 3, 3, 1, 1);
        drive(0, 0, 0, 1, 0, 9);
        check("relatch", 4, 2, 1, 0);
        drive(0, 0, 1, 0, 0, 0);
        check("relatch", 5, 0, 0, 0);

        // ---- final report ----
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
